mod_n_updown_counter: RTL and testbench

//   Parametrised modulo-N up/down counter with enable, synchronous load, wrap or
//   one-shot mode, terminal-count flag and a registered carry/borrow pulse for cascading.

---
 rtl/mod_n_updown_counter.sv | 113 +++++++++++
 tb/tb_mod_n_updown_counter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with enable, saturating synchronous load, wrap or one-shot
// mode, combinational terminal-count flag and a registered carry/borrow pulse.
module mod_n_updown_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             a_reset_n,
  input  logic             start,
  input  logic             up_dn,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             carry,
  output logic             done
);

  if ((MODULUS < 2) || (64'(MODULUS) > (64'd1 << WIDTH))) begin : g_bad_modulus
    $error("mod_n_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic             done_q,  done_d;

  logic [WIDTH-1:0] term_c;
  logic             at_term_c;
  logic [WIDTH-1:0] step_val_c;
  logic [WIDTH-1:0] wrap_val_c;

  // Terminal value and candidate next counts depend on the live direction input.
  always_comb begin
    term_c     = up_dn ? MAX_VAL : '0;
    at_term_c  = (count_q == term_c);
    step_val_c = up_dn ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
    wrap_val_c = up_dn ? '0 : MAX_VAL;
  end

  // Next-state logic: load beats stepping; carry only survives the wrapping edge.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    carry_d = 1'b0;
    done_d  = done_q;

    if (load) begin
      count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
      done_d  = 1'b0;
      state_d = start ? ST_RUN : ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_RUN: begin
          if (start) begin
            if (!at_term_c) begin
              count_d = step_val_c;
              state_d = ST_RUN;
            end else if (!mode) begin
              count_d = wrap_val_c;
              carry_d = 1'b1;
              state_d = ST_RUN;
            end else begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DONE: begin
          if (!start) begin
            done_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
        default: begin
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign carry = carry_q;
  assign done  = done_q;
  assign tc    = at_term_c;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Bench for mod_n_updown_counter: a MODULUS=10 and a MODULUS=16 instance share stimulus
// and are each compared every cycle against an arithmetic reference model.
module tb_mod_n_updown_counter;

  logic       clk = 1'b0;
  logic       a_reset_n;
  logic       start, up_dn, mode, load;
  logic [3:0] load_val;

  logic [3:0] cnt10, cnt16;
  logic       tc10, tc16, carry10, carry16, done10, done16;

  int checks = 0;
  int errors = 0;

  // Reference state: index 0 is the modulus-10 instance, index 1 the modulus-16 one.
  int mods [2] = '{10, 16};
  int m_cnt[2];
  int m_car[2];
  int m_don[2];

  always #5 clk = ~clk;

  mod_n_updown_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
    .clk(clk), .a_reset_n(a_reset_n), .start(start), .up_dn(up_dn), .mode(mode),
    .load(load), .load_val(load_val), .count(cnt10), .tc(tc10), .carry(carry10),
    .done(done10)
  );

  mod_n_updown_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk(clk), .a_reset_n(a_reset_n), .start(start), .up_dn(up_dn), .mode(mode),
    .load(load), .load_val(load_val), .count(cnt16), .tc(tc16), .carry(carry16),
    .done(done16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      m_car[k] = 0;
      m_don[k] = 0;
    end
  endfunction

  // One clock edge of the counter, described in terms of counting modulo m.
  function automatic void model_edge(int k);
    int m;
    int term;
    m = mods[k];
    term = up_dn ? m - 1 : 0;
    m_car[k] = 0;
    if (load) begin
      m_cnt[k] = (int'(load_val) >= m) ? m - 1 : int'(load_val);
      m_don[k] = 0;
    end else if (m_don[k] != 0) begin
      if (!start) m_don[k] = 0;
    end else if (start) begin
      if (m_cnt[k] != term)
        m_cnt[k] = up_dn ? m_cnt[k] + 1 : m_cnt[k] - 1;
      else if (!mode) begin
        m_cnt[k] = up_dn ? (m_cnt[k] + 1) % m : (m_cnt[k] + m - 1) % m;
        m_car[k] = 1;
      end else
        m_don[k] = 1;
    end
  endfunction

  task automatic check_all(input string tag);
    int t10, t16;
    t10 = (m_cnt[0] == (up_dn ? 9 : 0)) ? 1 : 0;
    t16 = (m_cnt[1] == (up_dn ? 15 : 0)) ? 1 : 0;
    chk({tag, "/cnt10"},   32'(cnt10),   32'(m_cnt[0]));
    chk({tag, "/carry10"}, 32'(carry10), 32'(m_car[0]));
    chk({tag, "/done10"},  32'(done10),  32'(m_don[0]));
    chk({tag, "/tc10"},    32'(tc10),    32'(t10));
    chk({tag, "/range10"}, 32'(int'(cnt10) < 10), 32'd1);
    chk({tag, "/cnt16"},   32'(cnt16),   32'(m_cnt[1]));
    chk({tag, "/carry16"}, 32'(carry16), 32'(m_car[1]));
    chk({tag, "/done16"},  32'(done16),  32'(m_don[1]));
    chk({tag, "/tc16"},    32'(tc16),    32'(t16));
  endtask

  // Advance one rising edge, update the model with the inputs seen at that edge, check.
  task automatic tick(input string tag);
    @(posedge clk);
    if (!a_reset_n) model_reset();
    else begin
      model_edge(0);
      model_edge(1);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    a_reset_n = 1'b0;
    start = 1'b0; up_dn = 1'b1; mode = 1'b0; load = 1'b0; load_val = '0;
    model_reset();
    #2;
    check_all("reset");
    tick("reset_hold");
    @(negedge clk);
    a_reset_n = 1'b1;

    // Async reset mid-cycle from count 7 in RUN
    load = 1'b1; load_val = 4'd7; start = 1'b1;
    tick("t1_load");
    load = 1'b0;
    #2;
    a_reset_n = 1'b0;
    #1;
    model_reset();
    check_all("t1_async");
    chk("t1_async_cnt", 32'(cnt10), 32'd0);
    tick("t1_held");
    tick("t1_held");
    @(negedge clk);
    a_reset_n = 1'b1;

    // Wrap up, 12 edges from 0
    start = 1'b1; up_dn = 1'b1; mode = 1'b0;
    repeat (12) tick("t2_wrap_up");
    chk("t2_end10", 32'(cnt10), 32'd2);
    chk("t2_end16", 32'(cnt16), 32'd12);

    // Wrap down from 0
    load = 1'b1; load_val = 4'd0;
    tick("t3_load0");
    load = 1'b0; up_dn = 1'b0;
    tick("t3_down");
    chk("t3_borrow", 32'(carry10), 32'd1);
    chk("t3_at9", 32'(cnt10), 32'd9);
    repeat (2) tick("t3_down");
    chk("t3_end", 32'(cnt10), 32'd7);

    // One-shot
    load = 1'b1; load_val = 4'd7; mode = 1'b1; up_dn = 1'b1; start = 1'b1;
    tick("t4_load7");
    load = 1'b0;
    repeat (4) tick("t4_oneshot");
    chk("t4_done", 32'(done10), 32'd1);
    chk("t4_held", 32'(cnt10), 32'd9);
    start = 1'b0;
    tick("t4_release");
    chk("t4_done_clr", 32'(done10), 32'd0);
    load = 1'b1; load_val = 4'd2; start = 1'b1;
    tick("t4_reload");
    load = 1'b0;
    tick("t4_resume");
    chk("t4_resume_cnt", 32'(cnt10), 32'd3);

    // Load clamp and load-over-start priority
    mode = 1'b0; start = 1'b0; load = 1'b1; load_val = 4'd13;
    tick("t5_clamp");
    chk("t5_clamp_cnt", 32'(cnt10), 32'd9);
    load_val = 4'd4;
    tick("t5_load4");
    load_val = 4'd6; start = 1'b1;
    tick("t5_load_wins");
    chk("t5_no_step", 32'(cnt10), 32'd6);
    load = 1'b0;

    // Enable gating from 3, then modulus-16 wrap 15 -> 0
    start = 1'b0; load = 1'b1; load_val = 4'd3; up_dn = 1'b1;
    tick("t6_load3");
    load = 1'b0;
    start = 1'b1; tick("t6_gate");
    start = 1'b0; tick("t6_gate");
    tick("t6_gate");
    start = 1'b1; tick("t6_gate");
    chk("t6_end", 32'(cnt10), 32'd5);
    load = 1'b1; load_val = 4'd14; start = 1'b0;
    tick("t6_load14");
    load = 1'b0; start = 1'b1;
    repeat (2) tick("t6_wrap16");
    chk("t6_cnt16", 32'(cnt16), 32'd0);
    chk("t6_carry16", 32'(carry16), 32'd1);

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      start    = ($urandom % 4) != 0;
      if (($urandom % 16) == 0) up_dn = ~up_dn;
      if (($urandom % 24) == 0) mode  = ~mode;
      load     = ($urandom % 12) == 0;
      load_val = 4'($urandom);
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
